// File: rtl/uart_cmd_responder.sv
// Command-frame responder: decodes 6-byte host frames from the UART RX strobe,
// runs one register write/read, and streams a 6-byte reply through the TX handshake.
module uart_cmd_responder #(
  parameter int          TIMEOUT_CLKS = 200000,
  parameter int          RD_LATENCY   = 1,
  parameter logic [7:0]  SYNC_RX      = 8'hA5,
  parameter logic [7:0]  SYNC_TX      = 8'h5A
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_send,
  input  logic        tx_ready,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_wr,
  output logic        reg_rd,
  input  logic [15:0] reg_rdata,
  output logic        busy,
  output logic        err_csum,
  output logic        err_timeout
);

  typedef enum logic [3:0] {
    HUNT, R_CMD, R_ADDR, R_DH, R_DL, R_CSUM, EXEC, RD_WAIT, TX_LOAD, TX_GAP
  } state_t;

  localparam int             TW      = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0]  TMAX    = TW'(TIMEOUT_CLKS);
  localparam logic [2:0]     RD_LAST = 3'(RD_LATENCY - 1);

  state_t        state, nxt;
  logic [TW-1:0] tcnt;
  logic [7:0]    cmd, addr_b, dh, dl, csum_b, sum, status, rep_dh, rep_dl;
  logic [2:0]    idx, rcnt;
  logic          rx_phase, tmo, csum_ok, cmd_wr, cmd_rd;
  logic [7:0]    tx_byte, tx_csum;

  assign rx_phase = state inside {R_CMD, R_ADDR, R_DH, R_DL, R_CSUM};
  assign tmo      = rx_phase && !rx_ready && (tcnt == TMAX);
  assign csum_ok  = (sum == csum_b);
  assign cmd_wr   = (cmd == 8'h01);
  assign cmd_rd   = (cmd == 8'h02);
  assign tx_csum  = status + addr_b + rep_dh + rep_dl;

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= HUNT;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      HUNT:    if (rx_ready && rx_data == SYNC_RX) nxt = R_CMD;
      R_CMD:   if (tmo) nxt = HUNT; else if (rx_ready) nxt = R_ADDR;
      R_ADDR:  if (tmo) nxt = HUNT; else if (rx_ready) nxt = R_DH;
      R_DH:    if (tmo) nxt = HUNT; else if (rx_ready) nxt = R_DL;
      R_DL:    if (tmo) nxt = HUNT; else if (rx_ready) nxt = R_CSUM;
      R_CSUM:  if (tmo) nxt = HUNT; else if (rx_ready) nxt = EXEC;
      EXEC:    nxt = (csum_ok && cmd_rd) ? RD_WAIT : TX_LOAD;
      RD_WAIT: if (rcnt == RD_LAST) nxt = TX_LOAD;
      TX_LOAD: if (tx_ready) nxt = TX_GAP;
      TX_GAP:  nxt = (idx == 3'd5) ? HUNT : TX_LOAD;
      default: nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tcnt <= '0; sum <= '0; cmd <= '0; addr_b <= '0; dh <= '0; dl <= '0;
      csum_b <= '0; status <= '0; rep_dh <= '0; rep_dl <= '0;
      idx <= '0; rcnt <= '0; reg_addr <= '0; reg_wdata <= '0;
    end else begin
      tcnt <= (rx_phase && !rx_ready && !tmo) ? tcnt + 1'b1 : '0;
      case (state)
        HUNT:   begin sum <= '0; idx <= '0; end
        R_CMD:  if (rx_ready) begin cmd    <= rx_data; sum <= sum + rx_data; end
        R_ADDR: if (rx_ready) begin addr_b <= rx_data; sum <= sum + rx_data; end
        R_DH:   if (rx_ready) begin dh     <= rx_data; sum <= sum + rx_data; end
        R_DL:   if (rx_ready) begin dl     <= rx_data; sum <= sum + rx_data; end
        // Bus address/data switch over as EXEC begins and then hold until the next frame.
        R_CSUM: if (rx_ready) begin
          csum_b    <= rx_data;
          reg_addr  <= addr_b;
          reg_wdata <= {dh, dl};
        end
        EXEC: begin
          status <= !csum_ok ? 8'h01 : (cmd_wr || cmd_rd) ? 8'h00 : 8'h02;
          rep_dh <= dh;
          rep_dl <= dl;
          rcnt   <= '0;
        end
        RD_WAIT: begin
          rcnt <= rcnt + 1'b1;
          if (rcnt == RD_LAST) {rep_dh, rep_dl} <= reg_rdata;
        end
        TX_GAP:  idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (idx)
      3'd1:    tx_byte = status;
      3'd2:    tx_byte = addr_b;
      3'd3:    tx_byte = rep_dh;
      3'd4:    tx_byte = rep_dl;
      3'd5:    tx_byte = tx_csum;
      default: tx_byte = SYNC_TX;
    endcase
  end

  always_comb begin
    busy        = (state != HUNT);
    tx_send     = (state == TX_LOAD) && tx_ready;
    tx_data     = tx_send ? tx_byte : 8'h00;
    reg_wr      = (state == EXEC) && csum_ok && cmd_wr;
    reg_rd      = (state == EXEC) && csum_ok && cmd_rd;
    err_csum    = (state == EXEC) && !csum_ok;
    err_timeout = tmo;
  end

endmodule
